uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter among NUM_REQ byte requesters, using round-robin arbitration.
- Latches the winner's byte and parity config, drives the TX launch handshake, and tracks TX busy through the full frame.
- Reports per-requester accept/complete pulses.
- Sits between system-side byte sources and the UART TX datapath, which runs on a slower prescaled bit clock, so handshakes are level-held until TX responds.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rr_pick.sv | 44 ++++
 rtl/uart_tx_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART TX arbitration slice.
package uart_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

  // Parity type encodings carried on req_par_typ / tx_par_typ.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Default number of clk cycles to wait for the TX side to go busy.
  localparam int LAUNCH_TMO_DEFAULT = 1023;

  // Parity bit the transmitter appends to a byte for a given parity type.
  function automatic logic par_bit(input logic [7:0] data, input logic typ);
    par_bit = (^data) ^ (typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin selector. Returns the first active
// requester at or after rr_ptr (wrapping modulo NUM_REQ) and whether any
// requester is active. Shared with the RX-side response mux.
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int GID_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GID_W-1:0]   rr_ptr,
  output logic [GID_W-1:0]   winner,
  output logic               any_req
);
  logic [NUM_REQ-1:0] rot_s;
  logic [GID_W-1:0]   off_s;
  logic [GID_W:0]     sum_s;

  // Rotate the request vector so that bit 0 is the requester at rr_ptr.
  assign rot_s = NUM_REQ'({req, req} >> rr_ptr);

  // Find the nearest active requester in the rotated vector (lowest offset wins).
  always_comb begin
    off_s   = '0;
    any_req = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        off_s   = GID_W'(i);
        any_req = 1'b1;
      end else begin
        off_s   = off_s;
      end
    end
  end

  // Map the rotated offset back to an absolute requester index.
  always_comb begin
    sum_s = {1'b0, rr_ptr} + {1'b0, off_s};
    if (sum_s >= (GID_W + 1)'(NUM_REQ)) begin
      winner = GID_W'(sum_s - (GID_W + 1)'(NUM_REQ));
    end else begin
      winner = GID_W'(sum_s);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte sources
// with round-robin arbitration. Handshakes with TX are level-held because the
// TX datapath runs on a slower bit clock; tx_busy arrives already synchronised.
// Optional feature: define UART_ARB_LOCK_EN to add req_lock, which keeps a
// requester's burst contiguous by re-granting it directly at frame done.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int GID_W      = 2,
  parameter int LAUNCH_TMO = LAUNCH_TMO_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_par_en,
  input  logic [NUM_REQ-1:0]   req_par_typ,
`ifdef UART_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]   req_lock,
`endif
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   done,
  output logic [NUM_REQ-1:0]   tmo_err,
  output logic                 tx_data_valid,
  output logic [7:0]           tx_p_data,
  output logic                 tx_par_en,
  output logic                 tx_par_typ,
  input  logic                 tx_busy,
  output logic [GID_W-1:0]     grant_id,
  output logic                 arb_busy
);
  localparam int CNT_W = $clog2(LAUNCH_TMO + 1);

  arb_state_e         state_r;
  logic [GID_W-1:0]   rr_ptr_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [GID_W-1:0]   grant_id_r;
  logic [7:0]         data_r;
  logic               par_en_r;
  logic               par_typ_r;
  logic               valid_r;
  logic [NUM_REQ-1:0] ack_r;
  logic [NUM_REQ-1:0] done_r;
  logic [NUM_REQ-1:0] tmo_r;
  logic               arb_busy_r;

  logic [GID_W-1:0]   win_s;
  logic               any_s;
  logic [GID_W-1:0]   sel_id_s;
  logic [7:0]         sel_data_s;
  logic               sel_pen_s;
  logic               sel_ptyp_s;
  logic [NUM_REQ-1:0] gid_oh_s;
  logic [GID_W-1:0]   rr_next_s;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GID_W   (GID_W)
  ) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr_r),
    .winner  (win_s),
    .any_req (any_s)
  );

  // The current owner re-latches its own byte in WAIT_DONE (locked burst);
  // otherwise the round-robin winner is the source.
  assign sel_id_s  = (state_r == WAIT_DONE) ? grant_id_r : win_s;
  assign gid_oh_s  = NUM_REQ'(1'b1) << grant_id_r;
  assign rr_next_s = (grant_id_r == GID_W'(NUM_REQ - 1)) ? '0 : grant_id_r + GID_W'(1'b1);

  // Select the byte and parity config of the requester being latched.
  always_comb begin
    sel_data_s = 8'h00;
    sel_pen_s  = 1'b0;
    sel_ptyp_s = PAR_EVEN;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (GID_W'(k) == sel_id_s) begin
        sel_data_s = req_data[8*k +: 8];
        sel_pen_s  = req_par_en[k];
        sel_ptyp_s = req_par_typ[k];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

`ifdef UART_ARB_LOCK_EN
  logic lock_hit_s;

  // A locked owner that still requests keeps the transmitter for its next byte.
  always_comb begin
    lock_hit_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (GID_W'(k) == grant_id_r) begin
        lock_hit_s = req_lock[k] & req[k];
      end else begin
        lock_hit_s = lock_hit_s;
      end
    end
  end
`endif

  // Arbitration FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      rr_ptr_r   <= '0;
      cnt_r      <= '0;
      grant_id_r <= '0;
      data_r     <= 8'h00;
      par_en_r   <= 1'b0;
      par_typ_r  <= PAR_EVEN;
      valid_r    <= 1'b0;
      ack_r      <= '0;
      done_r     <= '0;
      tmo_r      <= '0;
      arb_busy_r <= 1'b0;
    end else begin
      ack_r  <= '0;
      done_r <= '0;
      tmo_r  <= '0;
      case (state_r)
        IDLE: begin
          // A busy transmitter (e.g. a frame left over from reset) stalls arbitration.
          if (any_s && !tx_busy) begin
            grant_id_r <= win_s;
            data_r     <= sel_data_s;
            par_en_r   <= sel_pen_s;
            par_typ_r  <= sel_ptyp_s;
            valid_r    <= 1'b1;
            cnt_r      <= '0;
            arb_busy_r <= 1'b1;
            state_r    <= LAUNCH;
          end else begin
            state_r    <= IDLE;
          end
        end
        LAUNCH: begin
          if (tx_busy) begin
            ack_r    <= gid_oh_s;
            valid_r  <= 1'b0;
            rr_ptr_r <= rr_next_s;
            state_r  <= WAIT_DONE;
          end else if (cnt_r == CNT_W'(LAUNCH_TMO)) begin
            tmo_r      <= gid_oh_s;
            valid_r    <= 1'b0;
            rr_ptr_r   <= rr_next_s;
            arb_busy_r <= 1'b0;
            state_r    <= IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            done_r <= gid_oh_s;
`ifdef UART_ARB_LOCK_EN
            if (lock_hit_s) begin
              data_r    <= sel_data_s;
              par_en_r  <= sel_pen_s;
              par_typ_r <= sel_ptyp_s;
              valid_r   <= 1'b1;
              cnt_r     <= '0;
              state_r   <= LAUNCH;
            end else begin
              arb_busy_r <= 1'b0;
              state_r    <= IDLE;
            end
`else
            arb_busy_r <= 1'b0;
            state_r    <= IDLE;
`endif
          end else begin
            state_r <= WAIT_DONE;
          end
        end
        default: begin
          valid_r    <= 1'b0;
          arb_busy_r <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign ack           = ack_r;
  assign done          = done_r;
  assign tmo_err       = tmo_r;
  assign tx_data_valid = valid_r;
  assign tx_p_data     = data_r;
  assign tx_par_en     = par_en_r;
  assign tx_par_typ    = par_typ_r;
  assign grant_id      = grant_id_r;
  assign arb_busy      = arb_busy_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: self-checking bench. Inputs are driven and outputs are
// sampled on the falling clock edge; a round-robin reference model (pointer +
// modulo search) predicts every grant, byte and pulse.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int GW  = 2;
  localparam int TMO = 15;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, req_par_en, req_par_typ;
  logic [N*8-1:0] req_data;
`ifdef UART_ARB_LOCK_EN
  logic [N-1:0]   req_lock;
`endif
  logic [N-1:0]   ack, done, tmo_err;
  logic           tx_data_valid, tx_par_en, tx_par_typ, tx_busy, arb_busy;
  logic [7:0]     tx_p_data;
  logic [GW-1:0]  grant_id;

  int n_cmp  = 0;
  int n_fail = 0;
  int m_ptr  = 0;
  int served[N];
  int order_q[$];
  logic [7:0] m_data[N];
  logic       m_pen[N];
  logic       m_ptyp[N];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .GID_W(GW), .LAUNCH_TMO(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .req_par_en(req_par_en), .req_par_typ(req_par_typ),
`ifdef UART_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .ack(ack), .done(done), .tmo_err(tmo_err), .tx_data_valid(tx_data_valid),
    .tx_p_data(tx_p_data), .tx_par_en(tx_par_en), .tx_par_typ(tx_par_typ),
    .tx_busy(tx_busy), .grant_id(grant_id), .arb_busy(arb_busy)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference rule: first active requester at or after the pointer, wrapping.
  function automatic int rr_winner(input logic [N-1:0] r, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (r[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int k);
    logic [N-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic new_byte(input int k);
    m_data[k] = 8'($urandom_range(0, 255));
    m_pen[k]  = 1'($urandom_range(0, 1));
    m_ptyp[k] = 1'($urandom_range(0, 1));
    req_data[8*k +: 8] = m_data[k];
    req_par_en[k]      = m_pen[k];
    req_par_typ[k]     = m_ptyp[k];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_ptr = 0;
  endtask

  // TX model for one granted frame: busy rises after d idle cycles, stays for 1+h.
  task automatic finish_frame(input int w, input int d, input int h, input bit rereq);
    repeat (d) begin
      tick();
      n_cmp++;
      if ({tx_data_valid, tx_p_data, ack, tmo_err} !== {1'b1, m_data[w], {N{1'b0}}, {N{1'b0}}}) begin
        n_fail++;
        $display("FAIL launch_hold: got v=%0b data=%h ack=%b tmo=%b want v=1 data=%h", tx_data_valid, tx_p_data, ack, tmo_err, m_data[w]);
      end
    end
    tx_busy = 1'b1;
    tick();
    n_cmp++;
    if ({ack, tx_data_valid, done, tmo_err} !== {onehot(w), 1'b0, {N{1'b0}}, {N{1'b0}}}) begin
      n_fail++;
      $display("FAIL ack: got ack=%b v=%0b done=%b want ack=%b v=0", ack, tx_data_valid, done, onehot(w));
    end
    m_ptr = (w + 1) % N;
    served[w]++;
    order_q.push_back(w);
    if (rereq) new_byte(w);
    else req[w] = 1'b0;
    repeat (h) tick();
    tx_busy = 1'b0;
    tick();
    n_cmp++;
    if ({done, ack, tmo_err, arb_busy} !== {onehot(w), {N{1'b0}}, {N{1'b0}}, 1'b0}) begin
      n_fail++;
      $display("FAIL done: got done=%b ack=%b arb_busy=%0b want done=%b arb_busy=0", done, ack, arb_busy, onehot(w));
    end
  endtask

  // Run n frames from an idle DUT; the predicted grant is checked each frame.
  task automatic run_frames(input int n, input bit all_on);
    int w;
    for (int f = 0; f < n; f++) begin
      if (!all_on) begin
        for (int k = 0; k < N; k++) begin
          if (!req[k] && ($urandom_range(0, 1) == 1)) begin
            new_byte(k);
            req[k] = 1'b1;
          end
        end
        if (req == '0) begin
          w = $urandom_range(0, N - 1);
          new_byte(w);
          req[w] = 1'b1;
        end
      end
      w = rr_winner(req, m_ptr);
      tick();
      n_cmp++;
      if ({tx_data_valid, grant_id, tx_p_data, tx_par_en, tx_par_typ, arb_busy} !==
          {1'b1, GW'(w), m_data[w], m_pen[w], m_ptyp[w], 1'b1}) begin
        n_fail++;
        $display("FAIL grant: got v=%0b id=%0d data=%h pe=%0b pt=%0b want id=%0d data=%h pe=%0b pt=%0b",
                 tx_data_valid, grant_id, tx_p_data, tx_par_en, tx_par_typ, w, m_data[w], m_pen[w], m_ptyp[w]);
      end
      finish_frame(w, $urandom_range(0, 10), $urandom_range(0, 12), all_on);
    end
  endtask

  task automatic test_reset();
    req = '1;
    for (int k = 0; k < N; k++) new_byte(k);
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({tx_data_valid, ack, done, tmo_err, grant_id, tx_p_data, tx_par_en, tx_par_typ, arb_busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%0b ack=%b done=%b tmo=%b id=%0d data=%h busy=%0b want all 0",
               tx_data_valid, ack, done, tmo_err, grant_id, tx_p_data, arb_busy);
    end
    rst = 1'b0;
    req = '0;
    m_ptr = 0;
    tick();
    n_cmp++;
    if ({tx_data_valid, arb_busy, grant_id, tx_p_data} !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got v=%0b busy=%0b id=%0d data=%h want all 0", tx_data_valid, arb_busy, grant_id, tx_p_data);
    end
  endtask

  task automatic test_single();
    m_data[2] = 8'hA5; m_pen[2] = 1'b1; m_ptyp[2] = 1'b0;
    req_data[23:16] = 8'hA5; req_par_en[2] = 1'b1; req_par_typ[2] = 1'b0;
    req[2] = 1'b1;
    tick();
    n_cmp++;
    if ({tx_data_valid, grant_id, tx_p_data, tx_par_en, tx_par_typ} !== {1'b1, 2'd2, 8'hA5, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL single_grant: got v=%0b id=%0d data=%h pe=%0b pt=%0b want v=1 id=2 data=a5 pe=1 pt=0",
               tx_data_valid, grant_id, tx_p_data, tx_par_en, tx_par_typ);
    end
    finish_frame(2, 4, 159, 1'b0);
    repeat (3) tick();
    n_cmp++;
    if ({grant_id, tx_p_data, tx_data_valid, arb_busy} !== {2'd2, 8'hA5, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL retain_idle: got id=%0d data=%h v=%0b busy=%0b want id=2 data=a5 v=0 busy=0", grant_id, tx_p_data, tx_data_valid, arb_busy);
    end
  endtask

  task automatic test_busy_stall();
    tx_busy = 1'b1;
    new_byte(1);
    req[1] = 1'b1;
    repeat (5) begin
      tick();
      n_cmp++;
      if ({tx_data_valid, arb_busy, ack} !== {1'b0, 1'b0, {N{1'b0}}}) begin
        n_fail++;
        $display("FAIL busy_stall: got v=%0b arb_busy=%0b ack=%b want all 0", tx_data_valid, arb_busy, ack);
      end
    end
    tx_busy = 1'b0;
    tick();
    n_cmp++;
    if ({tx_data_valid, grant_id, tx_p_data} !== {1'b1, 2'd1, m_data[1]}) begin
      n_fail++;
      $display("FAIL stall_release: got v=%0b id=%0d data=%h want v=1 id=1 data=%h", tx_data_valid, grant_id, tx_p_data, m_data[1]);
    end
    finish_frame(1, 2, 3, 1'b0);
  endtask

  task automatic test_timeout();
    int a, b;
    a = m_ptr;
    b = (m_ptr + 2) % N;
    new_byte(a); new_byte(b);
    req[a] = 1'b1; req[b] = 1'b1;
    tick();
    n_cmp++;
    if ({tx_data_valid, grant_id} !== {1'b1, GW'(a)}) begin
      n_fail++;
      $display("FAIL tmo_grant: got v=%0b id=%0d want v=1 id=%0d", tx_data_valid, grant_id, a);
    end
    for (int i = 1; i <= TMO; i++) begin
      tick();
      n_cmp++;
      if ({tmo_err, tx_data_valid} !== {{N{1'b0}}, 1'b1}) begin
        n_fail++;
        $display("FAIL tmo_early: cycle %0d got tmo=%b v=%0b want tmo=0 v=1", i, tmo_err, tx_data_valid);
      end
    end
    tick();
    n_cmp++;
    if ({tmo_err, tx_data_valid, ack, arb_busy} !== {onehot(a), 1'b0, {N{1'b0}}, 1'b0}) begin
      n_fail++;
      $display("FAIL tmo_pulse: got tmo=%b v=%0b ack=%b busy=%0b want tmo=%b v=0", tmo_err, tx_data_valid, ack, arb_busy, onehot(a));
    end
    req[a] = 1'b0;
    m_ptr = (a + 1) % N;
    tick();
    n_cmp++;
    if ({tx_data_valid, grant_id, tx_p_data} !== {1'b1, GW'(b), m_data[b]}) begin
      n_fail++;
      $display("FAIL tmo_next: got v=%0b id=%0d data=%h want v=1 id=%0d data=%h", tx_data_valid, grant_id, tx_p_data, b, m_data[b]);
    end
    finish_frame(b, 3, 2, 1'b0);
  endtask

  task automatic test_fairness();
    int exp_ord;
    do_reset();
    order_q.delete();
    for (int k = 0; k < N; k++) begin
      served[k] = 0;
      new_byte(k);
    end
    req = '1;
    run_frames(2 * N, 1'b1);
    req = '0;
    for (int i = 0; i < order_q.size(); i++) begin
      exp_ord = i % N;
      n_cmp++;
      if (order_q[i] != exp_ord) begin
        n_fail++;
        $display("FAIL fair_order: frame %0d got %0d want %0d", i, order_q[i], exp_ord);
      end
    end
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (served[k] != 2) begin
        n_fail++;
        $display("FAIL fair_count: req %0d got %0d acks want 2", k, served[k]);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int w, j;
    w = $urandom_range(0, N - 1);
    new_byte(w);
    req[w] = 1'b1;
    tick();
    tx_busy = 1'b1;
    tick();
    n_cmp++;
    if (ack !== onehot(w)) begin
      n_fail++;
      $display("FAIL mid_ack: got ack=%b want %b", ack, onehot(w));
    end
    req[w] = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_ptr = 0;
    n_cmp++;
    if ({tx_data_valid, ack, done, tmo_err, grant_id, tx_p_data, tx_par_en, tx_par_typ, arb_busy} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%0b done=%b id=%0d data=%h busy=%0b want all 0", tx_data_valid, done, grant_id, tx_p_data, arb_busy);
    end
    j = $urandom_range(0, N - 1);
    new_byte(j);
    req[j] = 1'b1;
    repeat (4) begin
      tick();
      n_cmp++;
      if ({tx_data_valid, done} !== {1'b0, {N{1'b0}}}) begin
        n_fail++;
        $display("FAIL mid_stall: got v=%0b done=%b want 0", tx_data_valid, done);
      end
    end
    tx_busy = 1'b0;
    tick();
    n_cmp++;
    if ({done, tx_data_valid, grant_id, tx_p_data} !== {{N{1'b0}}, 1'b1, GW'(j), m_data[j]}) begin
      n_fail++;
      $display("FAIL mid_regrant: got done=%b v=%0b id=%0d data=%h want done=0 v=1 id=%0d data=%h",
               done, tx_data_valid, grant_id, tx_p_data, j, m_data[j]);
    end
    finish_frame(j, 1, 2, 1'b0);
  endtask

  task automatic test_random();
    run_frames(20, 1'b0);
    req = '0;
    tick();
  endtask

`ifdef UART_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    req = '0;
    new_byte(0); new_byte(1);
    req_lock[0] = 1'b1;
    req[0] = 1'b1; req[1] = 1'b1;
    tick();
    n_cmp++;
    if ({tx_data_valid, grant_id, tx_p_data} !== {1'b1, 2'd0, m_data[0]}) begin
      n_fail++;
      $display("FAIL lock_first: got v=%0b id=%0d data=%h want v=1 id=0 data=%h", tx_data_valid, grant_id, tx_p_data, m_data[0]);
    end
    for (int b = 0; b < 3; b++) begin
      repeat (2) tick();
      tx_busy = 1'b1;
      tick();
      n_cmp++;
      if (ack !== onehot(0)) begin
        n_fail++;
        $display("FAIL lock_ack: byte %0d got ack=%b want 0001", b, ack);
      end
      if (b < 2) new_byte(0);
      else begin
        req[0] = 1'b0;
        req_lock[0] = 1'b0;
      end
      m_ptr = 1;
      repeat (3) tick();
      tx_busy = 1'b0;
      tick();
      n_cmp++;
      if (b < 2) begin
        if ({done, tx_data_valid, grant_id, tx_p_data} !== {onehot(0), 1'b1, 2'd0, m_data[0]}) begin
          n_fail++;
          $display("FAIL lock_regrant: byte %0d got done=%b v=%0b id=%0d data=%h want id=0 data=%h", b, done, tx_data_valid, grant_id, tx_p_data, m_data[0]);
        end
      end else begin
        if ({done, tx_data_valid} !== {onehot(0), 1'b0}) begin
          n_fail++;
          $display("FAIL lock_end: got done=%b v=%0b want done=0001 v=0", done, tx_data_valid);
        end
      end
    end
    tick();
    n_cmp++;
    if ({tx_data_valid, grant_id, tx_p_data} !== {1'b1, 2'd1, m_data[1]}) begin
      n_fail++;
      $display("FAIL lock_next: got v=%0b id=%0d data=%h want v=1 id=1 data=%h", tx_data_valid, grant_id, tx_p_data, m_data[1]);
    end
    finish_frame(1, 2, 2, 1'b0);
  endtask
`endif

  initial begin
    rst = 1'b0;
    tx_busy = 1'b0;
    req = '0;
    req_data = '0;
    req_par_en = '0;
    req_par_typ = '0;
`ifdef UART_ARB_LOCK_EN
    req_lock = '0;
`endif
    for (int k = 0; k < N; k++) served[k] = 0;
    tick();
    test_reset();
    test_single();
    test_busy_stall();
    test_timeout();
    test_fairness();
    test_reset_mid();
    test_random();
`ifdef UART_ARB_LOCK_EN
    test_lock();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
